// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
// Sequencer states and the port index encoding used on the grant output.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_H = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection between the CPU and host ports.
// A port whose ack is high this cycle is masked so it cannot be re-granted
// while its requester is still seeing the completion pulse.
// Build macro MEM_ARB_ROUND_ROBIN_EN: when defined, ties go to the port named
// by prio (the one not granted last); otherwise C always wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic c_req,
    input  logic h_req,
    input  logic c_mask,
    input  logic h_mask,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic prio,
`endif
    output logic valid,
    output logic port
);

    logic c_live;
    logic h_live;

    // Mask acked ports, then resolve the winner.
    always_comb begin
        c_live = c_req & ~c_mask;
        h_live = h_req & ~h_mask;
        valid  = c_live | h_live;
        port   = PORT_C;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (c_live && h_live) begin
            port = prio;
        end else if (h_live) begin
            port = PORT_H;
        end
`else
        if (!c_live && h_live) begin
            port = PORT_H;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide memory port between the CPU (C) and the
// host/loader (H). Word accesses become two little-endian byte cycles; each
// granted transaction runs to completion before the next grant.
// Build macro MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; when it
// is undefined, C has fixed priority and no pointer register exists.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_word,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [15:0]       c_wdata,
    output logic [15:0]       c_rdata,
    output logic              c_ack,
    input  logic              h_req,
    input  logic              h_we,
    input  logic              h_word,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [15:0]       h_wdata,
    output logic [15:0]       h_rdata,
    output logic              h_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              grant
);

    state_t state_reg, state_next;

    logic              grant_reg, grant_next;
    logic              we_reg, we_next;
    logic              word_reg, word_next;
    logic [7:0]        wdata_hi_reg, wdata_hi_next;
    logic [7:0]        lo_reg, lo_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              mem_we_reg, mem_we_next;
    logic [7:0]        mem_wdata_reg, mem_wdata_next;
    logic [15:0]       c_rdata_reg, c_rdata_next;
    logic [15:0]       h_rdata_reg, h_rdata_next;
    logic              c_ack_reg, c_ack_next;
    logic              h_ack_reg, h_ack_next;

    logic              pick_valid;
    logic              pick_port;
    logic              sel_we;
    logic              sel_word;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_wdata;
    logic [15:0]       fin_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic prio_reg;

    // Pointer names the port that wins the next tie: the one not granted last.
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_reg <= PORT_C;
        end else if (state_reg == IDLE && pick_valid) begin
            prio_reg <= ~pick_port;
        end
    end
`endif

    mem_arb_pick u_pick (
        .c_req  (c_req),
        .h_req  (h_req),
        .c_mask (c_ack_reg),
        .h_mask (h_ack_reg),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .prio   (prio_reg),
`endif
        .valid  (pick_valid),
        .port   (pick_port)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> LO -> (HI for words) -> FIN -> IDLE.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (pick_valid) state_next = LO;
            LO:   state_next = word_reg ? HI : FIN;
            HI:   state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/datapath next values for each state.
    always_comb begin
        grant_next     = grant_reg;
        we_next        = we_reg;
        word_next      = word_reg;
        wdata_hi_next  = wdata_hi_reg;
        lo_next        = lo_reg;
        mem_addr_next  = mem_addr_reg;
        mem_we_next    = 1'b0;
        mem_wdata_next = mem_wdata_reg;
        c_rdata_next   = c_rdata_reg;
        h_rdata_next   = h_rdata_reg;
        c_ack_next     = 1'b0;
        h_ack_next     = 1'b0;

        sel_we    = (pick_port == PORT_H) ? h_we    : c_we;
        sel_word  = (pick_port == PORT_H) ? h_word  : c_word;
        sel_addr  = (pick_port == PORT_H) ? h_addr  : c_addr;
        sel_wdata = (pick_port == PORT_H) ? h_wdata : c_wdata;
        // In FIN mem_rdata carries the last byte fetched (the only byte for
        // a byte access, the high byte for a word access).
        fin_rdata = word_reg ? {mem_rdata, lo_reg} : {8'h00, mem_rdata};

        unique case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next     = pick_port;
                    we_next        = sel_we;
                    word_next      = sel_word;
                    wdata_hi_next  = sel_wdata[15:8];
                    mem_addr_next  = sel_addr;
                    mem_we_next    = sel_we;
                    mem_wdata_next = sel_wdata[7:0];
                end
            end
            LO: begin
                if (word_reg) begin
                    mem_addr_next  = mem_addr_reg + ADDR_W'(1);
                    mem_we_next    = we_reg;
                    mem_wdata_next = wdata_hi_reg;
                end
            end
            HI: begin
                lo_next = mem_rdata;
            end
            FIN: begin
                if (grant_reg == PORT_H) begin
                    h_ack_next = 1'b1;
                    if (!we_reg) h_rdata_next = fin_rdata;
                end else begin
                    c_ack_next = 1'b1;
                    if (!we_reg) c_rdata_next = fin_rdata;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; everything clears on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_reg     <= PORT_C;
            we_reg        <= 1'b0;
            word_reg      <= 1'b0;
            wdata_hi_reg  <= 8'h00;
            lo_reg        <= 8'h00;
            mem_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= 8'h00;
            c_rdata_reg   <= 16'h0000;
            h_rdata_reg   <= 16'h0000;
            c_ack_reg     <= 1'b0;
            h_ack_reg     <= 1'b0;
        end else begin
            grant_reg     <= grant_next;
            we_reg        <= we_next;
            word_reg      <= word_next;
            wdata_hi_reg  <= wdata_hi_next;
            lo_reg        <= lo_next;
            mem_addr_reg  <= mem_addr_next;
            mem_we_reg    <= mem_we_next;
            mem_wdata_reg <= mem_wdata_next;
            c_rdata_reg   <= c_rdata_next;
            h_rdata_reg   <= h_rdata_next;
            c_ack_reg     <= c_ack_next;
            h_ack_reg     <= h_ack_next;
        end
    end

    // Reset gates the write strobe directly so an aborted word write never
    // commits its second byte on the edge that samples reset.
    assign mem_we    = mem_we_reg & ~reset;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign c_rdata   = c_rdata_reg;
    assign h_rdata   = h_rdata_reg;
    assign c_ack     = c_ack_reg;
    assign h_ack     = h_ack_reg;
    assign busy      = (state_reg != IDLE);
    assign grant     = grant_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions on both ports checked
// against a byte-array memory image and the arbitration rules.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        c_req, c_we, c_word;
    logic [15:0] c_addr, c_wdata, c_rdata;
    logic        c_ack;
    logic        h_req, h_we, h_word;
    logic [15:0] h_addr, h_wdata, h_rdata;
    logic        h_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        grant;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.ADDR_W(16)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_word(c_word), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ack(c_ack),
        .h_req(h_req), .h_we(h_we), .h_word(h_word), .h_addr(h_addr),
        .h_wdata(h_wdata), .h_rdata(h_rdata), .h_ack(h_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        if (a == 16'h0010) return 8'h34;
        if (a == 16'h0011) return 8'h12;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Memory environment: synchronous read, byte writes.
    logic [7:0] mem [0:65535];
    bit loaded = 1'b0;
    always @(posedge clock) begin
        if (!loaded) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_byte(16'(i));
            loaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Event counters, sampled at the edge (pre-update values).
    int we_pulses = 0;
    int c_acks = 0;
    int h_acks = 0;
    always @(posedge clock) begin
        if (mem_we === 1'b1) we_pulses++;
        if (c_ack === 1'b1) c_acks++;
        if (h_ack === 1'b1) h_acks++;
    end

    // Reference state.
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] exp_c = 16'h0000;
    logic [15:0] exp_h = 16'h0000;
    logic        model_prio = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input logic port, input logic we, input logic word,
                          input logic [15:0] addr, input logic [15:0] wdata, input bit hold);
        int lat, we0, ack0, we_exp;
        logic [15:0] a1;
        a1 = addr + 16'd1;
        we0 = we_pulses;
        ack0 = c_acks + h_acks;
        if (port) begin
            h_req = 1'b1; h_we = we; h_word = word; h_addr = addr; h_wdata = wdata;
        end else begin
            c_req = 1'b1; c_we = we; c_word = word; c_addr = addr; c_wdata = wdata;
        end
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (i == 1) begin
                check("busy_t1", 32'(busy), 32'd1);
                check("grant_t1", 32'(grant), 32'(port));
            end
            if ((port ? h_ack : c_ack) === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("ack_latency", lat, word ? 32'd4 : 32'd3);
        if (hold) begin
            @(negedge clock);
            check("no_regrant", 32'(busy), 32'd0);
        end
        c_req = 1'b0;
        h_req = 1'b0;
        @(negedge clock);
        check("ack_count", c_acks + h_acks - ack0, 32'd1);
        we_exp = we ? (word ? 2 : 1) : 0;
        check("we_pulses", we_pulses - we0, we_exp);
        if (we) begin
            ref_mem[addr] = wdata[7:0];
            if (word) ref_mem[a1] = wdata[15:8];
            check("mem_lo", 32'(mem[addr]), 32'(ref_mem[addr]));
            if (word) check("mem_hi", 32'(mem[a1]), 32'(ref_mem[a1]));
        end else begin
            if (port) exp_h = word ? {ref_mem[a1], ref_mem[addr]} : {8'h00, ref_mem[addr]};
            else      exp_c = word ? {ref_mem[a1], ref_mem[addr]} : {8'h00, ref_mem[addr]};
        end
        check("c_rdata", 32'(c_rdata), 32'(exp_c));
        check("h_rdata", 32'(h_rdata), 32'(exp_h));
        if (RR) model_prio = ~port;
        $display("txn port=%0d we=%0d word=%0d addr=%04h wdata=%04h lat=%0d c_rdata=%04h h_rdata=%04h",
                 port, we, word, addr, wdata, lat, c_rdata, h_rdata);
    endtask

    // Both ports raise a byte read together; each drops at its own ack.
    task automatic tie_pair();
        logic exp_first;
        int t_c, t_h;
        exp_first = RR ? model_prio : 1'b0;
        c_we = 1'b0; c_word = 1'b0; c_addr = 16'h0010;
        h_we = 1'b0; h_word = 1'b0; h_addr = 16'h0011;
        c_req = 1'b1; h_req = 1'b1;
        t_c = 0; t_h = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (c_ack === 1'b1 && t_c == 0) begin t_c = i; c_req = 1'b0; end
            if (h_ack === 1'b1 && t_h == 0) begin t_h = i; h_req = 1'b0; end
            if (t_c != 0 && t_h != 0) break;
        end
        c_req = 1'b0; h_req = 1'b0;
        // Winner acks at +3; the loser is granted in that ack cycle.
        check("tie_c_ack_cycle", t_c, (exp_first == 1'b0) ? 32'd3 : 32'd6);
        check("tie_h_ack_cycle", t_h, (exp_first == 1'b1) ? 32'd3 : 32'd6);
        exp_c = {8'h00, ref_mem[16'h0010]};
        exp_h = {8'h00, ref_mem[16'h0011]};
        check("tie_c_rdata", 32'(c_rdata), 32'(exp_c));
        check("tie_h_rdata", 32'(h_rdata), 32'(exp_h));
        if (RR) model_prio = exp_first;
        $display("tie first=%0d c_ack_at=%0d h_ack_at=%0d", exp_first, t_c, t_h);
        @(negedge clock);
    endtask

    initial begin
        logic [15:0] old41;
        logic        exp_next;
        int          n_acks;
        bit          stop;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
        reset = 1'b1;
        c_req = 0; c_we = 0; c_word = 0; c_addr = 0; c_wdata = 0;
        h_req = 0; h_we = 0; h_word = 0; h_addr = 0; h_wdata = 0;
        repeat (3) @(negedge clock);

        // Reset state.
        check("rst_c_rdata", 32'(c_rdata), 32'd0);
        check("rst_h_rdata", 32'(h_rdata), 32'd0);
        check("rst_acks", 32'({c_ack, h_ack}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed transactions.
        do_txn(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0);
        check("c_word_read_1234", 32'(c_rdata), 32'h1234);
        do_txn(1'b1, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0);
        check("mem_20_EF", 32'(mem[16'h0020]), 32'hEF);
        check("mem_21_BE", 32'(mem[16'h0021]), 32'hBE);
        do_txn(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, 1'b0);
        check("c_byte_read_BE", 32'(c_rdata), 32'h00BE);
        do_txn(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
        check("wrap_read", 32'(h_rdata), 32'({init_byte(16'h0000), init_byte(16'hFFFF)}));
        do_txn(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b1);

        // Randomized single-port transactions.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 3) == 0) ? (16'hFFFF - 16'($urandom_range(0, 1)))
                                            : 16'($urandom_range(0, 255));
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), a, 16'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Reset during HI of an H word write.
        old41 = {8'h00, mem[16'h0041]};
        h_req = 1'b1; h_we = 1'b1; h_word = 1'b1; h_addr = 16'h0040; h_wdata = 16'hCAFE;
        @(negedge clock);
        @(negedge clock);
        check("abort_in_hi_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        h_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_c_rdata", 32'(c_rdata), 32'd0);
        check("abort_h_rdata", 32'(h_rdata), 32'd0);
        n_acks = c_acks + h_acks;
        repeat (4) @(negedge clock);
        check("abort_no_ack", c_acks + h_acks - n_acks, 32'd0);
        ref_mem[16'h0040] = 8'hFE;
        check("abort_mem_lo", 32'(mem[16'h0040]), 32'hFE);
        check("abort_mem_hi_kept", 32'(mem[16'h0041]), 32'(old41));
        exp_c = 16'h0000; exp_h = 16'h0000; model_prio = 1'b0;
        $display("reset abort: busy=%0d mem[40]=%02h mem[41]=%02h", busy, mem[16'h0040], mem[16'h0041]);
        do_txn(1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 1'b0);

        // Tie resolution.
        tie_pair();
        tie_pair();

        // Both ports requesting continuously: the acked port is masked, so
        // the waiting port takes every ack cycle and grants alternate.
        exp_next = RR ? model_prio : 1'b0;
        c_we = 1'b0; c_word = 1'b0; c_addr = 16'h0010;
        h_we = 1'b0; h_word = 1'b0; h_addr = 16'h0011;
        c_req = 1'b1; h_req = 1'b1;
        n_acks = 0; stop = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (i == 24) stop = 1'b1;
            if (c_ack === 1'b1 || h_ack === 1'b1) begin
                check("alt_single_ack", 32'(c_ack & h_ack), 32'd0);
                check("alt_port", 32'(h_ack), 32'(exp_next));
                check("alt_rdata", 32'(h_ack ? h_rdata : c_rdata),
                      32'({8'h00, ref_mem[h_ack ? 16'h0011 : 16'h0010]}));
                $display("alt ack cycle=%0d port=%0d", i, h_ack);
                n_acks++;
                if (RR) model_prio = ~h_ack;
                exp_next = ~exp_next;
                if (stop) begin
                    if (h_ack) h_req = 1'b0;
                    else c_req = 1'b0;
                end
            end
            if (!c_req && !h_req && !busy) break;
        end
        c_req = 1'b0; h_req = 1'b0;
        check("alt_ack_total", n_acks, 32'd9);
        @(negedge clock);
        check("alt_drained", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
